led_serial_host: RTL and testbench

Parallel-to-serial host adapter for the bit-serial LED-128 core (`led_serial`).
- Accepts one 128-bit key and one 64-bit plaintext per request over a valid/ready handshake.
- Shifts both into the core MSB-first, pulses `start`, waits for the core to finish, then shifts the 64-bit ciphertext out of the core.
- Presents the ciphertext on a valid/ready response port.
- Sits directly upstream and downstream of the core: it owns all core-side control and serial data pins.

---
 rtl/led_serial_host.sv | 153 +++++++++++++++
 tb/tb_led_serial_host.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_serial_host.sv
// Parallel-to-serial host adapter for the bit-serial LED-128 core: loads key and
// plaintext MSB-first, starts the core, waits for completion and shifts out the ciphertext.
module led_serial_host #(
    parameter int unsigned TIMEOUT = 4095
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [127:0] key_in,
    input  logic [63:0]  pt_in,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [63:0]  ct_out,
    output logic         rsp_err,
    output logic         busy,
    output logic         core_keyi,
    output logic         core_datai,
    output logic         core_loadkey,
    output logic         core_loadpt,
    output logic         core_getct,
    output logic         core_start,
    input  logic         core_dataq,
    input  logic         core_done
);

    localparam int unsigned KEY_W  = 128;
    localparam int unsigned BLK_W  = 64;
    localparam int unsigned BCNT_W = 7;
    localparam int unsigned TCNT_W = 16;

    localparam logic [BCNT_W-1:0] KEY_LAST = BCNT_W'(KEY_W - 1);
    localparam logic [BCNT_W-1:0] BLK_LAST = BCNT_W'(BLK_W - 1);
    localparam logic [TCNT_W-1:0] TMO      = TCNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LDKEY,
        S_LDPT,
        S_START,
        S_WAITLO,
        S_WAITHI,
        S_GETCT,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_timeout;
    logic [KEY_W-1:0]    r_ksh;
    logic [BLK_W-1:0]    r_psh;
    logic [BLK_W-1:0]    r_csh;
    logic [BCNT_W-1:0]   r_bcnt;
    logic [TCNT_W-1:0]   r_tcnt;
    logic                r_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; the wait timeout takes priority over core_done.
    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE:   if (req_valid) w_next = S_LDKEY;
            S_LDKEY:  if (r_bcnt == KEY_LAST) w_next = S_LDPT;
            S_LDPT:   if (r_bcnt == BLK_LAST) w_next = S_START;
            S_START:  w_next = S_WAITLO;
            S_WAITLO: begin
                if (r_tcnt == TMO) begin
                    w_timeout = 1'b1;
                    w_next    = S_RESP;
                end else if (!core_done) begin
                    w_next = S_WAITHI;
                end
            end
            S_WAITHI: begin
                if (r_tcnt == TMO) begin
                    w_timeout = 1'b1;
                    w_next    = S_RESP;
                end else if (core_done) begin
                    w_next = S_GETCT;
                end
            end
            S_GETCT:  if (r_bcnt == BLK_LAST) w_next = S_RESP;
            S_RESP:   if (rsp_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Shift registers, counters and the error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ksh  <= '0;
            r_psh  <= '0;
            r_csh  <= '0;
            r_bcnt <= '0;
            r_tcnt <= '0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_ksh  <= key_in;
                        r_psh  <= pt_in;
                        r_bcnt <= '0;
                        r_tcnt <= '0;
                        r_err  <= 1'b0;
                    end
                end
                S_LDKEY: begin
                    r_ksh  <= {r_ksh[KEY_W-2:0], 1'b0};
                    r_bcnt <= (r_bcnt == KEY_LAST) ? '0 : r_bcnt + BCNT_W'(1);
                end
                S_LDPT: begin
                    r_psh  <= {r_psh[BLK_W-2:0], 1'b0};
                    r_bcnt <= r_bcnt + BCNT_W'(1);
                end
                S_WAITLO, S_WAITHI: begin
                    r_tcnt <= r_tcnt + TCNT_W'(1);
                    if (w_timeout) begin
                        r_csh <= '0;
                        r_err <= 1'b1;
                    end
                    if (w_next == S_GETCT) r_bcnt <= '0;
                end
                S_GETCT: begin
                    r_csh  <= {r_csh[BLK_W-2:0], core_dataq};
                    r_bcnt <= r_bcnt + BCNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign req_ready    = (r_state == S_IDLE);
    assign busy         = (r_state != S_IDLE);
    assign rsp_valid    = (r_state == S_RESP);
    assign rsp_err      = r_err;
    assign ct_out       = r_csh;
    assign core_keyi    = r_ksh[KEY_W-1];
    assign core_datai   = r_psh[BLK_W-1];
    assign core_loadkey = (r_state == S_LDKEY);
    assign core_loadpt  = (r_state == S_LDPT);
    assign core_start   = (r_state == S_START);
    assign core_getct   = (r_state == S_GETCT);

endmodule

// File: tb/tb_led_serial_host.sv
// Bench for led_serial_host: a behavioural core stub plus a queue-based scoreboard
// checking ciphertext, error flag, latency and strobe counts per transaction.
module tb_led_serial_host;

    localparam int unsigned TMO       = 2100;
    localparam int          NOM_LAT   = 2303;
    localparam int          TMO_LAT   = 195 + TMO;
    localparam int          CORE_BUSY = 2044;
    localparam int          M_NORM    = 0;
    localparam int          M_HI      = 1;
    localparam int          M_LO      = 2;
    localparam int          M_FIX     = 3;
    localparam logic [63:0] FIX_CT    = 64'hDEAD_BEEF_0123_4567;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [127:0] key_in = '0;
    logic [63:0]  pt_in = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [63:0]  ct_out;
    logic         rsp_err;
    logic         busy;
    logic         core_keyi, core_datai, core_loadkey, core_loadpt, core_getct, core_start;
    logic         core_dataq, core_done;

    always #5 clk = ~clk;

    led_serial_host #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .key_in(key_in), .pt_in(pt_in),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .ct_out(ct_out), .rsp_err(rsp_err), .busy(busy),
        .core_keyi(core_keyi), .core_datai(core_datai),
        .core_loadkey(core_loadkey), .core_loadpt(core_loadpt),
        .core_getct(core_getct), .core_start(core_start),
        .core_dataq(core_dataq), .core_done(core_done)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stand-in cipher: any keyed mixing works, it only has to expose serialization errors.
    function automatic logic [63:0] ref_cipher(input logic [127:0] k, input logic [63:0] p);
        logic [63:0] x;
        x = p;
        for (int r = 0; r < 4; r++) begin
            x = x ^ ((r % 2 == 1) ? k[63:0] : k[127:64]);
            x = {x[50:0], x[63:51]} + 64'h9E37_79B9_7F4A_7C15;
        end
        return x;
    endfunction

    // Core stub: collects serial bits, stays busy CORE_BUSY cycles after start, shifts ct out.
    int           mode = M_NORM;
    logic [127:0] s_key;
    logic [63:0]  s_pt, s_ct;
    int           s_cnt;
    logic         s_done;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_key <= '0; s_pt <= '0; s_ct <= '0; s_cnt <= 0; s_done <= 1'b1;
        end else begin
            if (core_loadkey) s_key <= {s_key[126:0], core_keyi};
            if (core_loadpt)  s_pt  <= {s_pt[62:0], core_datai};
            if (core_getct)   s_ct  <= {s_ct[62:0], 1'b0};
            if (core_start) begin
                s_cnt  <= CORE_BUSY;
                s_done <= 1'b0;
                s_ct   <= (mode == M_FIX) ? FIX_CT : ref_cipher(s_key, s_pt);
            end else if (s_cnt > 1) begin
                s_cnt <= s_cnt - 1;
            end else if (s_cnt == 1) begin
                s_cnt  <= 0;
                s_done <= 1'b1;
            end
        end
    end

    assign core_dataq = s_ct[63];
    assign core_done  = (mode == M_HI) ? 1'b1 : (mode == M_LO) ? 1'b0 : s_done;

    typedef struct {
        logic [63:0] ct;
        logic        err;
        int          c;
        int          lat;
        int          ngetct;
    } exp_t;

    exp_t sb[$];

    // Monitor: strobe bookkeeping and response comparison against the scoreboard.
    int          n_lk = 0, n_lp = 0, n_st = 0, n_gc = 0, n_multi = 0;
    int          first_cyc = 0;
    bit          in_rsp = 1'b0;
    logic [63:0] held_ct;
    logic        held_err;
    exp_t        e;

    always @(negedge clk) begin
        if (!reset) begin
            n_lk = 0; n_lp = 0; n_st = 0; n_gc = 0; n_multi = 0; in_rsp = 1'b0;
        end else begin
            n_lk += int'(core_loadkey);
            n_lp += int'(core_loadpt);
            n_st += int'(core_start);
            n_gc += int'(core_getct);
            if ($countones({core_loadkey, core_loadpt, core_start, core_getct}) > 1) n_multi++;
            if (rsp_valid) begin
                if (!in_rsp) begin
                    in_rsp    = 1'b1;
                    first_cyc = cyc;
                    held_ct   = ct_out;
                    held_err  = rsp_err;
                end else begin
                    check("ct_hold", 128'(ct_out), 128'(held_ct));
                    check("err_hold", 128'(rsp_err), 128'(held_err));
                end
                if (rsp_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_rsp: got ct %0h with empty scoreboard", ct_out);
                    end else begin
                        e = sb.pop_front();
                        check("ct_out", 128'(ct_out), 128'(e.ct));
                        check("rsp_err", 128'(rsp_err), 128'(e.err));
                        check("latency", 128'(first_cyc - e.c), 128'(e.lat));
                        check("n_loadkey", 128'(n_lk), 128'(128));
                        check("n_loadpt", 128'(n_lp), 128'(64));
                        check("n_start", 128'(n_st), 128'(1));
                        check("n_getct", 128'(n_gc), 128'(e.ngetct));
                        check("strobe_overlap", 128'(n_multi), 128'(0));
                    end
                    n_lk = 0; n_lp = 0; n_st = 0; n_gc = 0; n_multi = 0; in_rsp = 1'b0;
                end
            end
        end
    end

    bit rand_ready = 1'b1;
    initial forever begin
        @(posedge clk); #1;
        if (rand_ready) rsp_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic do_req(input logic [127:0] k, input logic [63:0] p, input int m, output int c);
        int   n;
        logic err;
        n = 0;
        c = -1;
        while (!req_ready && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL req_ready_wait: got 0 expected 1 within 5000 cycles");
            return;
        end
        err       = (m == M_HI) || (m == M_LO);
        mode      = m;
        key_in    = k;
        pt_in     = p;
        req_valid = 1'b1;
        c         = cyc;
        sb.push_back('{ct: err ? 64'h0 : (m == M_FIX) ? FIX_CT : ref_cipher(k, p),
                       err: err, c: cyc, lat: err ? TMO_LAT : NOM_LAT,
                       ngetct: err ? 0 : 64});
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 6000) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: got %0d pending responses expected 0", sb.size());
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req_ready"}, 128'(req_ready), 128'(1));
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_rsp_valid"}, 128'(rsp_valid), 128'(0));
        check({tag, "_rsp_err"}, 128'(rsp_err), 128'(0));
        check({tag, "_ct_out"}, 128'(ct_out), 128'(0));
        check({tag, "_core_pins"},
              128'({core_keyi, core_datai, core_loadkey, core_loadpt, core_getct, core_start}),
              128'(0));
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        int           c;
        int           n;
        logic [127:0] k1, k2;
        logic [63:0]  p1, p2, ct1;

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        reset = 1'b1;
        @(posedge clk); #1;

        do_req(128'h0, 64'h0, M_NORM, c);
        k1 = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
        p1 = 64'hF000_0000_0000_000F;
        do_req(k1, p1, M_NORM, c);
        drain();
        check("stub_key", s_key, k1);
        check("stub_pt", 128'(s_pt), 128'(p1));

        do_req(rnd128(), 64'(rnd128()), M_FIX, c);

        // Abort mid-LDKEY with an asynchronous reset.
        do_req(rnd128(), 64'(rnd128()), M_NORM, c);
        while (cyc < c + 50) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        #1;
        check_reset_vals("abort");
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        do_req(rnd128(), 64'(rnd128()), M_NORM, c);
        do_req(rnd128(), 64'(rnd128()), M_HI, c);
        do_req(rnd128(), 64'(rnd128()), M_LO, c);
        for (int i = 0; i < 6; i++) do_req(rnd128(), 64'(rnd128()), M_NORM, c);
        drain();

        // Back-pressure: response held while a second request waits.
        rand_ready = 1'b0;
        rsp_ready  = 1'b0;
        k1 = rnd128(); p1 = 64'(rnd128());
        k2 = rnd128(); p2 = 64'(rnd128());
        ct1 = ref_cipher(k1, p1);
        do_req(k1, p1, M_NORM, c);
        n = 0;
        while (!rsp_valid && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_rsp_valid", 128'(rsp_valid), 128'(1));
        key_in    = k2;
        pt_in     = p2;
        req_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            check("bp_req_ready", 128'(req_ready), 128'(0));
            check("bp_ct_out", 128'(ct_out), 128'(ct1));
            check("bp_strobes",
                  128'({core_loadkey, core_loadpt, core_getct, core_start}), 128'(0));
        end
        rsp_ready = 1'b1;
        sb.push_back('{ct: ref_cipher(k2, p2), err: 1'b0, c: cyc + 1, lat: NOM_LAT, ngetct: 64});
        @(posedge clk); #1;
        check("bp_idle_ready", 128'(req_ready), 128'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("bp_accepted", 128'(busy), 128'(1));
        rand_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded 90000 cycles");
        $fatal(1, "watchdog");
    end

endmodule
